// File: rtl/init_sequencer.sv
// init_sequencer: fills the first row and first column of an (N+1)x(N+1)
// alignment score matrix with multiples of gap_score. When the fill is done
// it hands the RAM write port over to the fill engine.
// Optional feature macro: INIT_SETTLE_EN adds a SETTLE wait of SETTLE_CYCLES
// cycles between the last init write and DONE.
module init_sequencer #(
    parameter int N             = 128,
    parameter int gap_score     = -2,
    parameter int SETTLE_CYCLES = 2,
    localparam int AW           = $clog2((N+1)*(N+1))
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 fill_req,
    input  logic [AW-1:0]        fill_addr,
    input  logic signed [8:0]    fill_data,
    output logic                 fill_gnt,
    output logic                 ram_we,
    output logic [AW-1:0]        ram_addr,
    output logic signed [8:0]    ram_data,
    output logic                 busy,
    output logic                 end_init
);

    // idx runs one past N in COL so that the exit decision sits in the cycle
    // after the final write has been registered.
    localparam int               IW       = $clog2(N+2);
    localparam logic [IW-1:0]    IDX_LAST = IW'(N);
    localparam logic [IW-1:0]    IDX_END  = IW'(N+1);
    localparam logic [AW-1:0]    STRIDE   = AW'(N+1);
    localparam logic signed [8:0] GAP     = 9'(gap_score);

    typedef enum logic [2:0] {
        IDLE,
        ROW,
        COL,
        DONE
`ifdef INIT_SETTLE_EN
        , SETTLE
`endif
    } state_t;

    state_t               state;
    logic [IW-1:0]        idx;
    logic signed [8:0]    acc;
    logic [AW-1:0]        addr;

`ifdef INIT_SETTLE_EN
    localparam int            SW          = $clog2(SETTLE_CYCLES+2);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES-1);
    logic [SW-1:0]        settle_cnt;
`endif

    // Fill engine only owns the port in DONE; a restart pulse takes precedence.
    assign fill_gnt = (state == DONE) && fill_req && !stall && !start;

    // Main sequencer: state, address/score generation and the registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            acc      <= '0;
            addr     <= '0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
            busy     <= 1'b0;
            end_init <= 1'b0;
`ifdef INIT_SETTLE_EN
            settle_cnt <= '0;
`endif
        end else begin
            ram_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ROW;
                        idx   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ROW: begin
                    if (!stall) begin
                        ram_we   <= 1'b1;
                        ram_addr <= AW'(idx);
                        ram_data <= acc;
                        if (idx == IDX_LAST) begin
                            state <= COL;
                            idx   <= IW'(1);
                            acc   <= GAP;
                            addr  <= STRIDE;
                        end else begin
                            idx <= idx + 1'b1;
                            acc <= acc + GAP;
                        end
                    end
                end
                COL: begin
                    if (idx == IDX_END) begin
`ifdef INIT_SETTLE_EN
                        state      <= SETTLE;
                        settle_cnt <= '0;
`else
                        state    <= DONE;
                        busy     <= 1'b0;
                        end_init <= 1'b1;
`endif
                    end else if (!stall) begin
                        ram_we   <= 1'b1;
                        ram_addr <= addr;
                        ram_data <= acc;
                        addr     <= addr + STRIDE;
                        idx      <= idx + 1'b1;
                        acc      <= acc + GAP;
                    end
                end
`ifdef INIT_SETTLE_EN
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        end_init <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
`endif
                DONE: begin
                    if (start) begin
                        state    <= ROW;
                        idx      <= '0;
                        acc      <= '0;
                        busy     <= 1'b1;
                        end_init <= 1'b0;
                    end else if (fill_gnt) begin
                        ram_we   <= 1'b1;
                        ram_addr <= fill_addr;
                        ram_data <= fill_data;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_init_sequencer.sv
// tb_init_sequencer: directed sequence with randomized stall/start/fill
// traffic, checked against a list-of-writes reference model.
module tb_init_sequencer;

    localparam int N       = 4;
    localparam int GAP     = -2;
    localparam int SETTLE  = 2;
    localparam int AW      = $clog2((N+1)*(N+1));
`ifdef INIT_SETTLE_EN
    localparam int EXP_LAT = SETTLE + 1;
`else
    localparam int EXP_LAT = 1;
`endif

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 stall;
    logic                 fill_req;
    logic [AW-1:0]        fill_addr;
    logic signed [8:0]    fill_data;
    logic                 fill_gnt;
    logic                 ram_we;
    logic [AW-1:0]        ram_addr;
    logic signed [8:0]    ram_data;
    logic                 busy;
    logic                 end_init;

    int checks   = 0;
    int failures = 0;

    int expAddr[$];
    int expData[$];
    int lastAddr = 0;
    int lastData = 0;

    init_sequencer #(
        .N             (N),
        .gap_score     (GAP),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stall     (stall),
        .fill_req  (fill_req),
        .fill_addr (fill_addr),
        .fill_data (fill_data),
        .fill_gnt  (fill_gnt),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .busy      (busy),
        .end_init  (end_init)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something stalls the directed sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int wrap9(input int v);
        logic signed [8:0] t;
        t = 9'(v);
        return int'(t);
    endfunction

    // Reference: row cells 0..N then column cells (N+1)..N(N+1), score = step*gap.
    function automatic void buildExpected();
        expAddr.delete();
        expData.delete();
        for (int i = 0; i <= N; i++) begin
            expAddr.push_back(i);
            expData.push_back(wrap9(i * GAP));
        end
        for (int i = 1; i <= N; i++) begin
            expAddr.push_back(i * (N + 1));
            expData.push_back(wrap9(i * GAP));
        end
    endfunction

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, capture the combinational grant, then step past the edge.
    task automatic applyStimulus(input logic r, input logic st, input logic s, input logic rq,
                                 input logic [AW-1:0] a, input logic signed [8:0] d,
                                 output logic gnt);
        rst       = r;
        start     = st;
        stall     = s;
        fill_req  = rq;
        fill_addr = a;
        fill_data = d;
        #1;
        gnt = fill_gnt;
        @(posedge clk);
        #1;
    endtask

    // Run an init sequence (start already taken) for max_writes writes, then check end_init timing.
    task automatic runInit(input int stall_pct, input int max_writes);
        int   writes;
        int   cycles;
        int   total;
        int   k;
        logic s;
        logic st;
        logic rq;
        logic gnt;
        writes = 0;
        cycles = 0;
        buildExpected();
        total = expAddr.size();
        while (writes < max_writes && cycles < 400) begin
            s  = ($urandom_range(0, 99) < stall_pct);
            st = ($urandom_range(0, 9) == 0);
            rq = 1'($urandom_range(0, 1));
            applyStimulus(1'b0, st, s, rq, AW'($urandom_range(0, 24)), 9'($urandom), gnt);
            cycles++;
            checkOutput("init_gnt", gnt, 0);
            checkOutput("init_busy", busy, 1);
            checkOutput("init_end", end_init, 0);
            if (s) begin
                checkOutput("stall_we", ram_we, 0);
                checkOutput("stall_addr", ram_addr, lastAddr);
                checkOutput("stall_data", ram_data, lastData);
            end else begin
                lastAddr = expAddr.pop_front();
                lastData = expData.pop_front();
                writes++;
                checkOutput("init_we", ram_we, 1);
                checkOutput("init_addr", ram_addr, lastAddr);
                checkOutput("init_data", ram_data, lastData);
            end
        end
        if (writes < max_writes)
            checkOutput("init_timeout", writes, max_writes);
        if (max_writes == total) begin
            k = 0;
            do begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, gnt);
                k++;
                if (!end_init) begin
                    checkOutput("settle_busy", busy, 1);
                    checkOutput("settle_we", ram_we, 0);
                end
            end while (!end_init && k < 20);
            checkOutput("end_init_latency", k, EXP_LAT);
            checkOutput("done_busy", busy, 0);
            checkOutput("done_we", ram_we, 0);
        end
    endtask

    initial begin
        logic gnt;
        logic s;
        logic rq;
        logic [AW-1:0] a;
        logic signed [8:0] d;

        // Reset wins over start and fill traffic.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, AW'(6), 9'sd5, gnt);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, AW'(6), 9'sd5, gnt);
        checkOutput("rst_gnt", gnt, 0);
        checkOutput("rst_we", ram_we, 0);
        checkOutput("rst_addr", ram_addr, 0);
        checkOutput("rst_data", ram_data, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_end", end_init, 0);

        // Idle: fill requests are ignored.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, AW'(6), 9'sd5, gnt);
            checkOutput("idle_gnt", gnt, 0);
            checkOutput("idle_we", ram_we, 0);
            checkOutput("idle_busy", busy, 0);
        end

        // Clean sequence with no stalls.
        $display("[TB] clean init sequence");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, gnt);
        checkOutput("start_busy", busy, 1);
        checkOutput("start_we", ram_we, 0);
        runInit(0, 2 * N + 1);

        // Fill traffic in DONE with random stalls.
        $display("[TB] fill traffic in DONE");
        for (int i = 0; i < 16; i++) begin
            s  = 1'($urandom_range(0, 1));
            rq = 1'($urandom_range(0, 1));
            a  = AW'($urandom_range(0, 24));
            d  = 9'($urandom);
            applyStimulus(1'b0, 1'b0, s, rq, a, d, gnt);
            checkOutput("fill_gnt", gnt, rq & !s);
            checkOutput("fill_we", ram_we, rq & !s);
            checkOutput("fill_end", end_init, 1);
            if (rq && !s) begin
                lastAddr = int'(a);
                lastData = int'(d);
                checkOutput("fill_addr", ram_addr, lastAddr);
                checkOutput("fill_data", ram_data, lastData);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, AW'(6), 9'sd5, gnt);
        checkOutput("stalled_gnt", gnt, 0);
        checkOutput("stalled_we", ram_we, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, AW'(6), 9'sd5, gnt);
        lastAddr = 6;
        lastData = 5;
        checkOutput("unstalled_gnt", gnt, 1);
        checkOutput("unstalled_we", ram_we, 1);
        checkOutput("unstalled_addr", ram_addr, 6);
        checkOutput("unstalled_data", ram_data, 5);

        // Restart from DONE while a fill request is pending.
        $display("[TB] restart from DONE with stalls");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, AW'(6), 9'sd5, gnt);
        checkOutput("restart_gnt", gnt, 0);
        checkOutput("restart_end", end_init, 0);
        checkOutput("restart_busy", busy, 1);
        checkOutput("restart_we", ram_we, 0);
        checkOutput("restart_gnt_after", fill_gnt, 0);
        runInit(30, 2 * N + 1);

        // Reset mid-column, right after the (N+1)*2 cell is written.
        $display("[TB] reset mid-column");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, gnt);
        runInit(25, N + 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, AW'(6), 9'sd5, gnt);
        lastAddr = 0;
        lastData = 0;
        checkOutput("midrst_we", ram_we, 0);
        checkOutput("midrst_addr", ram_addr, 0);
        checkOutput("midrst_data", ram_data, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_end", end_init, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, AW'(6), 9'sd5, gnt);
            checkOutput("postrst_gnt", gnt, 0);
            checkOutput("postrst_we", ram_we, 0);
            checkOutput("postrst_busy", busy, 0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, gnt);
        runInit(20, 2 * N + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
